// File: rtl/kudu_dv_pkg.sv
// Shared kudu DV types: arbiter FSM states and requester count.
package kudu_dv_pkg;

  localparam int unsigned ARB_NREQ = 2;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbHold0,
    ArbHold1
  } arb_state_e;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of 1-bit owner IDs for granted, still-unanswered OBI transactions.
module obi_arb_id_fifo #(
  parameter int unsigned Depth = 8,
  localparam int unsigned Aw = $clog2(Depth)
) (
  input  logic        clk_wr,
  input  logic        rst_ni,
  input  logic        push,
  input  logic        pop,
  input  logic        din,
  output logic        head,
  output logic        full,
  output logic        empty,
  output logic [Aw:0] count
);

  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic [Depth-1:0] mem_q;

  always_ff @(posedge clk_wr or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[Aw-1:0]] <= din;
        wr_ptr_q                <= wr_ptr_q + (Aw + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (Aw + 1)'(1);
      end
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[Aw-1:0]];

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-master round-robin OBI arbiter sharing one memory-model slave port.
module obi_mem_arbiter
  import kudu_dv_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned OUTST_DEPTH = 8
) (
  input  logic          clk_wr,
  input  logic          rst_ni,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [3:0]    m0_be,
  input  logic [3:0]    m1_be,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_err,
  output logic          m1_err,
  output logic          s_req,
  output logic          s_we,
  output logic [3:0]    s_be,
  output logic [31:0]   s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_gnt,
  input  logic          s_rvalid,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_err,
  output logic [4:0]    outst_cnt,
  output logic          protocol_err
);

  localparam int unsigned CntW = $clog2(OUTST_DEPTH) + 1;

  arb_state_e          state_q;
  logic                last_owner_q;
  logic                protocol_err_q;
  logic [ARB_NREQ-1:0] req;
  logic                sel, sel_valid;
  logic                push, pop;
  logic                fifo_head, fifo_full, fifo_empty;
  logic [CntW-1:0]     fifo_count;

  assign req = {m1_req, m0_req};

  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        if (!fifo_full) begin
          sel_valid = |req;
          sel       = (&req) ? ~last_owner_q : req[1];
        end
      end
      // A held address phase stays on its master; only that master's request matters.
      ArbHold0: begin
        sel       = 1'b0;
        sel_valid = m0_req;
      end
      ArbHold1: begin
        sel       = 1'b1;
        sel_valid = m1_req;
      end
      default: ;
    endcase
  end

  assign s_req   = sel_valid;
  assign s_we    = s_req & (sel ? m1_we : m0_we);
  assign s_be    = s_req ? (sel ? m1_be : m0_be) : '0;
  assign s_addr  = s_req ? (sel ? m1_addr : m0_addr) : '0;
  assign s_wdata = s_req ? (sel ? m1_wdata : m0_wdata) : '0;

  assign push   = s_req & s_gnt;
  assign pop    = s_rvalid & ~fifo_empty;
  assign m0_gnt = push & ~sel;
  assign m1_gnt = push & sel;

  assign m0_rvalid = pop & ~fifo_head;
  assign m1_rvalid = pop & fifo_head;
  assign m0_rdata  = m0_rvalid ? s_rdata : '0;
  assign m1_rdata  = m1_rvalid ? s_rdata : '0;
  assign m0_err    = m0_rvalid & s_err;
  assign m1_err    = m1_rvalid & s_err;

  assign outst_cnt    = 5'(fifo_count);
  assign protocol_err = protocol_err_q;

  always_ff @(posedge clk_wr or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ArbIdle;
      last_owner_q   <= 1'b1;
      protocol_err_q <= 1'b0;
    end else begin
      if (s_rvalid && fifo_empty) begin
        protocol_err_q <= 1'b1;
      end
      unique case (state_q)
        ArbIdle: begin
          if (push) begin
            last_owner_q <= sel;
          end else if (s_req) begin
            state_q <= sel ? ArbHold1 : ArbHold0;
          end
        end
        ArbHold0, ArbHold1: begin
          if (push) begin
            last_owner_q <= sel;
            state_q      <= ArbIdle;
          end else if (!s_req) begin
            // Request withdrawn before grant.
            protocol_err_q <= 1'b1;
            state_q        <= ArbIdle;
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  obi_arb_id_fifo #(
    .Depth(OUTST_DEPTH)
  ) u_id_fifo (
    .clk_wr(clk_wr),
    .rst_ni(rst_ni),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed vector table, hand sequences and a queue-based model.
module tb_obi_mem_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk_wr = 1'b0;
  logic          rst_ni = 1'b0;
  logic          m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic [3:0]    m0_be = '0, m1_be = '0;
  logic [31:0]   m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_req, s_we;
  logic [3:0]    s_be;
  logic [31:0]   s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_gnt = 1'b0, s_rvalid = 1'b0, s_err = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  logic [4:0]    outst_cnt;
  logic          protocol_err;

  always #5 clk_wr = ~clk_wr;

  obi_mem_arbiter #(
    .DW(DW),
    .OUTST_DEPTH(DEPTH)
  ) dut (
    .clk_wr(clk_wr), .rst_ni(rst_ni),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_be(m0_be), .m1_be(m1_be), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .outst_cnt(outst_cnt), .protocol_err(protocol_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of owners awaiting a response, a locked master while
  // an address phase waits for its grant, and the round-robin memory.
  int q[$];
  int lock = -1;
  int last = 1;
  bit perr = 1'b0;
  bit mg0, mg1;

  function automatic void model_reset();
    q.delete();
    lock = -1;
    last = 1;
    perr = 1'b0;
  endfunction

  task automatic eval_and_check();
    bit r[2];
    bit sreq, rv, g;
    int sel, head;
    r[0] = m0_req;
    r[1] = m1_req;
    sreq = 1'b0;
    sel  = 0;
    if (lock >= 0) begin
      sel  = lock;
      sreq = r[lock];
    end else if (q.size() < DEPTH) begin
      if (r[0] && r[1]) begin
        sel  = 1 - last;
        sreq = 1'b1;
      end else if (r[0] || r[1]) begin
        sel  = r[1] ? 1 : 0;
        sreq = 1'b1;
      end
    end
    g    = sreq && s_gnt;
    rv   = s_rvalid && (q.size() > 0);
    head = (q.size() > 0) ? q[0] : -1;
    mg0  = g && (sel == 0);
    mg1  = g && (sel == 1);

    check("m0_gnt", m0_gnt, mg0);
    check("m1_gnt", m1_gnt, mg1);
    check("s_req", s_req, sreq);
    check("s_addr", s_addr, sreq ? (sel == 1 ? m1_addr : m0_addr) : 32'h0);
    check("s_we", s_we, sreq ? (sel == 1 ? m1_we : m0_we) : 1'b0);
    check("s_be", s_be, sreq ? (sel == 1 ? m1_be : m0_be) : 4'h0);
    check("s_wdata", s_wdata, sreq ? (sel == 1 ? m1_wdata : m0_wdata) : '0);
    check("m0_rvalid", m0_rvalid, rv && head == 0);
    check("m1_rvalid", m1_rvalid, rv && head == 1);
    check("m0_rdata", m0_rdata, (rv && head == 0) ? s_rdata : '0);
    check("m1_rdata", m1_rdata, (rv && head == 1) ? s_rdata : '0);
    check("m0_err", m0_err, rv && head == 0 && s_err);
    check("m1_err", m1_err, rv && head == 1 && s_err);
    check("outst_cnt", outst_cnt, q.size());
    check("protocol_err", protocol_err, perr);

    // State after the coming edge: pop before push.
    if (s_rvalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else perr = 1'b1;
    end
    if (g) begin
      q.push_back(sel);
      last = sel;
      lock = -1;
    end else if (lock >= 0) begin
      if (!r[lock]) begin
        perr = 1'b1;
        lock = -1;
      end
    end else if (sreq) begin
      lock = sel;
    end
  endtask

  task automatic step(input bit r0, input bit r1, input bit g, input bit rv,
                      input logic [31:0] rd, input bit er);
    @(negedge clk_wr);
    m0_req   = r0;
    m1_req   = r1;
    s_gnt    = g;
    s_rvalid = rv;
    s_rdata  = rd;
    s_err    = er;
    #2;
    eval_and_check();
  endtask

  task automatic do_reset();
    @(negedge clk_wr);
    {m0_req, m1_req, m0_we, m1_we, s_gnt, s_rvalid, s_err} = '0;
    {m0_be, m1_be, m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata} = '0;
    #3 rst_ni = 1'b0;
    #1;
    check("rst_outst_cnt", outst_cnt, 5'd0);
    check("rst_protocol_err", protocol_err, 1'b0);
    check("rst_s_req", s_req, 1'b0);
    check("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    check("rst_err", {m0_err, m1_err}, 2'b00);
    check("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    check("rst_s_phase", {s_we, s_be, s_addr}, 37'h0);
    check("rst_s_wdata", s_wdata, '0);
    model_reset();
    @(negedge clk_wr);
    #1 rst_ni = 1'b1;
  endtask

  typedef struct {
    bit          do_rst;
    bit          r0, r1, g, rv;
    logic [31:0] rd;
    bit          x_g0, x_g1, x_rv0, x_rv1;
    int          x_cnt;
    int          x_sel;  // 2: no slave request expected
  } vec_t;

  vec_t tv[$];

  function automatic void add(bit d, bit r0, bit r1, bit g, bit rv, logic [31:0] rd,
                              bit g0, bit g1, bit v0, bit v1, int cnt, int sel);
    tv.push_back('{d, r0, r1, g, rv, rd, g0, g1, v0, v1, cnt, sel});
  endfunction

  bit p0, p1;

  initial begin
    // Single read
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    // Tie, alternating from m0
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 2, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 3, 1);
    add(0, 0, 0, 0, 1, 32'h11, 0, 0, 1, 0, 4, 2);
    add(0, 0, 0, 0, 1, 32'h22, 0, 0, 0, 1, 3, 2);
    add(0, 0, 0, 0, 1, 32'h33, 0, 0, 1, 0, 2, 2);
    add(0, 0, 0, 0, 1, 32'h44, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    // Ordering m0, m1, m1, m0
    add(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 2, 1);
    add(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 1, 32'hA0, 0, 0, 1, 0, 4, 2);
    add(0, 0, 0, 0, 1, 32'hA1, 0, 0, 0, 1, 3, 2);
    add(0, 0, 0, 0, 1, 32'hA2, 0, 0, 0, 1, 2, 2);
    add(0, 0, 0, 0, 1, 32'hA3, 0, 0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    // Hold: m1 waits 3 cycles, m0 cannot preempt
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 32'hB1, 0, 0, 0, 1, 2, 2);
    add(0, 0, 0, 0, 1, 32'hB0, 0, 0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    foreach (tv[i]) begin
      if (tv[i].do_rst) begin
        do_reset();
        m0_addr = 32'h100;
        m1_addr = 32'h200;
      end else begin
        step(tv[i].r0, tv[i].r1, tv[i].g, tv[i].rv, tv[i].rd, 1'b0);
        check($sformatf("tv%0d_gnt", i), {m0_gnt, m1_gnt}, {tv[i].x_g0, tv[i].x_g1});
        check($sformatf("tv%0d_rvalid", i), {m0_rvalid, m1_rvalid}, {tv[i].x_rv0, tv[i].x_rv1});
        check($sformatf("tv%0d_cnt", i), outst_cnt, tv[i].x_cnt);
        check($sformatf("tv%0d_s_req", i), s_req, tv[i].x_sel != 2);
        if (tv[i].x_sel != 2)
          check($sformatf("tv%0d_s_addr", i), s_addr, tv[i].x_sel == 1 ? 32'h200 : 32'h100);
        if (tv[i].x_rv0) check($sformatf("tv%0d_m0_rdata", i), m0_rdata, tv[i].rd);
        if (tv[i].x_rv1) check($sformatf("tv%0d_m1_rdata", i), m1_rdata, tv[i].rd);
      end
    end

    // Full: eight grants, then arbitration stalls until a response frees a slot
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    check("full_cnt", outst_cnt, 5'd8);
    check("full_s_req", s_req, 1'b0);
    check("full_no_gnt", m0_gnt, 1'b0);
    step(1, 0, 1, 1, 32'hC0, 0);
    check("full_pop_s_req", s_req, 1'b0);
    step(1, 0, 1, 0, 0, 0);
    check("full_resume_s_req", s_req, 1'b1);
    check("full_resume_gnt", m0_gnt, 1'b1);
    check("full_resume_cnt", outst_cnt, 5'd7);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 32'hC100 + i, i[0]);
    step(0, 0, 0, 0, 0, 0);
    check("full_drained", outst_cnt, 5'd0);

    // Errors: stray response, sticky flag, reset with outstanding IDs
    step(0, 0, 0, 1, 32'hBAD, 0);
    check("stray_no_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    step(0, 0, 0, 0, 0, 0);
    check("stray_perr", protocol_err, 1'b1);
    step(0, 0, 0, 0, 0, 0);
    check("stray_perr_sticky", protocol_err, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("pre_rst_cnt", outst_cnt, 5'd3);
    do_reset();
    step(0, 0, 0, 1, 32'hFEED, 0);
    check("post_rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    step(0, 0, 0, 0, 0, 0);
    check("post_rst_perr", protocol_err, 1'b1);

    // Randomized traffic against the model; requests are held until granted
    do_reset();
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_wr);
      if (!p0 && ($urandom_range(2) == 0)) begin
        p0 = 1'b1;
        m0_addr = $urandom; m0_we = 1'($urandom); m0_be = 4'($urandom); m0_wdata = $urandom;
      end
      if (!p1 && ($urandom_range(2) == 0)) begin
        p1 = 1'b1;
        m1_addr = $urandom; m1_we = 1'($urandom); m1_be = 4'($urandom); m1_wdata = $urandom;
      end
      m0_req   = p0;
      m1_req   = p1;
      s_gnt    = ($urandom_range(3) != 0);
      s_rvalid = ((q.size() > 0) && ($urandom_range(3) < 2)) || ($urandom_range(99) == 0);
      s_rdata  = $urandom;
      s_err    = ($urandom_range(7) == 0);
      #2;
      eval_and_check();
      if (mg0) p0 = 1'b0;
      if (mg1) p1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
